// File: rtl/iobus_out_demux.sv
// Steers CPU IOBUS stores onto NUM_PORTS registered valid/ready output ports, with an overrun/flush control word.
// Optional combinational status/data readback on IOBUS_IN when IOBUS_OUT_DEMUX_STATUS_READ_EN is defined.
module iobus_out_demux #(
    parameter int unsigned NUM_PORTS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             IOBUS_ADDR,
    input  logic [31:0]             IOBUS_OUT,
    input  logic                    IOBUS_WR,
    output logic [32*NUM_PORTS-1:0] PORT_DATA,
    output logic [NUM_PORTS-1:0]    PORT_VALID,
    input  logic [NUM_PORTS-1:0]    PORT_READY,
    output logic [NUM_PORTS-1:0]    OVERRUN,
    output logic                    ADDR_ERR,
    output logic [31:0]             IOBUS_IN
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FLUSH_BIT = 31;
    localparam logic [31:0] CTRL_OFS  = 32'(4 * NUM_PORTS);
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } port_state_e;

    port_state_e              state_q [NUM_PORTS];
    port_state_e              state_d [NUM_PORTS];
    logic [DATA_W-1:0]        data_q  [NUM_PORTS];
    logic [DATA_W-1:0]        data_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0]     ovr_q;
    logic [NUM_PORTS-1:0]     ovr_d;
    logic                     addr_err_q;
    logic                     addr_err_d;

    logic [31:0]              offset_c;
    logic                     aligned_c;
    logic                     in_win_c;
    logic [NUM_PORTS-1:0]     port_hit_c;
    logic                     ctrl_hit_c;
    logic                     err_c;
    logic                     flush_c;
    logic [NUM_PORTS-1:0]     clr_c;
    logic [NUM_PORTS-1:0]     ovr_set_c;

    // Address decode; addresses below BASE_ADDR wrap to a large offset and fall outside the window
    always_comb begin
        offset_c  = IOBUS_ADDR - BASE_ADDR;
        aligned_c = (IOBUS_ADDR[1:0] == 2'b00);
        in_win_c  = (offset_c <= (CTRL_OFS + 32'd3));
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_hit_c[i] = IOBUS_WR && aligned_c && (offset_c == 32'(4 * i));
        end
        ctrl_hit_c = IOBUS_WR && aligned_c && (offset_c == CTRL_OFS);
        err_c      = IOBUS_WR && in_win_c && !aligned_c;
        flush_c    = ctrl_hit_c && IOBUS_OUT[FLUSH_BIT];
        clr_c      = ctrl_hit_c ? IOBUS_OUT[NUM_PORTS-1:0] : '0;
    end

    // Per-port handshake FSMs plus overrun and error next-state
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ovr_set_c  = '0;
        addr_err_d = err_c;
        for (int i = 0; i < NUM_PORTS; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (port_hit_c[i]) begin
                        data_d[i]  = IOBUS_OUT;
                        state_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (port_hit_c[i]) begin
                        data_d[i]    = IOBUS_OUT;
                        ovr_set_c[i] = !PORT_READY[i];
                    end else if (PORT_READY[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (flush_c) begin
                state_d[i] = ST_IDLE;
            end
        end
        // A new overrun takes priority over a coincident clear
        ovr_d = (ovr_q & ~clr_c) | ovr_set_c;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                data_q[i]  <= '0;
            end
            ovr_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            ovr_q      <= ovr_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
        assign PORT_DATA[DATA_W*g +: DATA_W] = data_q[g];
        assign PORT_VALID[g]                 = (state_q[g] == ST_PENDING);
    end

    assign OVERRUN  = ovr_q;
    assign ADDR_ERR = addr_err_q;

`ifdef IOBUS_OUT_DEMUX_STATUS_READ_EN
    logic [31:0] rd_c;

    // Same-cycle readback of the status word or a port's data register
    always_comb begin
        rd_c = '0;
        if (IOBUS_ADDR == CTRL_ADDR) begin
            rd_c = {8'h00, 8'(ovr_q), 8'h00, 8'(PORT_VALID)};
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IOBUS_ADDR == (BASE_ADDR + 32'(4 * i))) begin
                rd_c = data_q[i];
            end
        end
    end

    assign IOBUS_IN = rd_c;
`else
    assign IOBUS_IN = 32'h0;
`endif

endmodule

// File: tb/tb_iobus_out_demux.sv
// Scoreboard bench for iobus_out_demux: a behavioural model pushes expected post-edge state, compared after each edge.
module tb_iobus_out_demux;

    localparam int unsigned NP   = 4;
    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam logic [31:0] CTRL = 32'h1100_0010;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [31:0]   IOBUS_ADDR = '0;
    logic [31:0]   IOBUS_OUT  = '0;
    logic          IOBUS_WR   = 1'b0;
    logic [127:0]  PORT_DATA;
    logic [NP-1:0] PORT_VALID;
    logic [NP-1:0] PORT_READY = '0;
    logic [NP-1:0] OVERRUN;
    logic          ADDR_ERR;
    logic [31:0]   IOBUS_IN;

    iobus_out_demux #(.NUM_PORTS(NP), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .PORT_DATA(PORT_DATA), .PORT_VALID(PORT_VALID),
        .PORT_READY(PORT_READY), .OVERRUN(OVERRUN), .ADDR_ERR(ADDR_ERR),
        .IOBUS_IN(IOBUS_IN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [127:0]  data;
        logic [NP-1:0] valid;
        logic [NP-1:0] ovr;
        logic          err;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   m = '0;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] r;
        r = 32'h0;
`ifdef IOBUS_OUT_DEMUX_STATUS_READ_EN
        if (addr == CTRL) r = {8'h00, 4'h0, m.ovr, 8'h00, 4'h0, m.valid};
        for (int k = 0; k < NP; k++)
            if (addr == BASE + 32'(4 * k)) r = m.data[32*k +: 32];
`endif
        return r;
    endfunction

    // Drive one cycle, push the model's expected post-edge state, then compare it
    task automatic step(input logic rst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [NP-1:0] rdy);
        exp_t        n;
        exp_t        got;
        logic [31:0] ofs;
        RST = rst; IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = wdata; PORT_READY = rdy;
        ofs = addr - BASE;
        if (rst) begin
            n = '0;
        end else begin
            n       = m;
            n.err   = wr && (addr >= BASE) && (addr <= CTRL + 32'd3) && (addr[1:0] != 2'b00);
            n.valid = m.valid & ~rdy;
            if (wr && addr[1:0] == 2'b00 && addr >= BASE && addr < CTRL) begin
                int j;
                j = int'(ofs >> 2);
                n.data[32*j +: 32] = wdata;
                n.valid[j] = 1'b1;
                if (m.valid[j] && !rdy[j]) n.ovr[j] = 1'b1;
            end
            if (wr && addr == CTRL) begin
                n.ovr = m.ovr & ~wdata[NP-1:0];
                if (wdata[31]) n.valid = '0;
            end
        end
        sb_q.push_back(n);
        m = n;
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        for (int p = 0; p < NP; p++)
            check($sformatf("data%0d", p), PORT_DATA[32*p +: 32], got.data[32*p +: 32]);
        check("valid", 32'(PORT_VALID), 32'(got.valid));
        check("overrun", 32'(OVERRUN), 32'(got.ovr));
        check("addr_err", 32'(ADDR_ERR), 32'(got.err));
        check("iobus_in", IOBUS_IN, model_read(IOBUS_ADDR));
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [NP-1:0] rdy);
        step(1'b0, 1'b1, addr, wdata, rdy);
    endtask

    task automatic idle(input logic [NP-1:0] rdy);
        step(1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] addrs [10];
        logic [31:0] a;
        logic [31:0] d;
        addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, CTRL, BASE + 6, CTRL + 2,
                  BASE - 4, CTRL + 4, BASE + 1};

        step(1'b1, 1'b0, 32'h0, 32'h0, '0);
        step(1'b1, 1'b0, 32'h0, 32'h0, '0);
        repeat (5) idle('0);

        // Port 2 store, held pending, then accepted
        store(BASE + 8, 32'hDEAD_BEEF, '0);
        check("p2_data_direct", PORT_DATA[95:64], 32'hDEAD_BEEF);
        check("p2_valid_direct", 32'(PORT_VALID[2]), 32'd1);
        repeat (3) idle('0);
        idle(4'b0100);
        check("p2_accepted", 32'(PORT_VALID[2]), 32'd0);
        check("p2_data_held", PORT_DATA[95:64], 32'hDEAD_BEEF);

        // Overrun on port 1, clear it, then a same-cycle accept+store
        store(BASE + 4, 32'h0000_AAAA, '0);
        store(BASE + 4, 32'h0000_1234, '0);
        check("p1_overrun_direct", 32'(OVERRUN[1]), 32'd1);
        check("p1_data_direct", PORT_DATA[63:32], 32'h0000_1234);
        store(CTRL, 32'h0000_0002, '0);
        check("p1_overrun_clr", 32'(OVERRUN[1]), 32'd0);
        store(BASE + 4, 32'h0000_5678, 4'b0010);
        check("p1_no_overrun", 32'(OVERRUN[1]), 32'd0);

        // Flush with ports 0 and 3 pending
        store(BASE, 32'h0000_0011, '0);
        store(BASE + 12, 32'h0000_0033, '0);
        store(CTRL, 32'h8000_0000, '0);
        check("flush_valid", 32'(PORT_VALID), 32'd0);
        check("flush_keeps_p3", PORT_DATA[127:96], 32'h0000_0033);

        // Bad and foreign addresses
        store(BASE + 6, 32'hFFFF_FFFF, '0);
        check("err_pulse", 32'(ADDR_ERR), 32'd1);
        idle('0);
        check("err_one_cycle", 32'(ADDR_ERR), 32'd0);
        store(BASE - 4, 32'hFFFF_FFFF, '0);
        store(CTRL + 2, 32'hFFFF_FFFF, '0);
        store(CTRL + 4, 32'hFFFF_FFFF, '0);

        // Build VALID=0101, OVERRUN=0010 and read the status word
        store(BASE + 4, 32'h0000_0101, '0);
        store(BASE + 4, 32'h0000_0102, '0);
        idle(4'b0010);
        store(BASE, 32'h0000_0200, '0);
        store(BASE + 8, 32'h0000_0300, '0);
        IOBUS_ADDR = CTRL;
        #1;
`ifdef IOBUS_OUT_DEMUX_STATUS_READ_EN
        check("status_word", IOBUS_IN, 32'h0002_0005);
        IOBUS_ADDR = BASE + 8;
        #1;
        check("port2_readback", IOBUS_IN, 32'h0000_0300);
`else
        check("status_tied", IOBUS_IN, 32'h0);
`endif

        // Randomised traffic against the model
        for (int t = 0; t < 300; t++) begin
            a = addrs[$urandom_range(0, 9)];
            d = $urandom;
            if (a == CTRL && $urandom_range(0, 3) != 0) d[31] = 1'b0;
            if ($urandom_range(0, 2) == 0) idle(NP'($urandom));
            else store(a, d, NP'($urandom));
        end

        // Reset while pending
        store(BASE + 12, 32'h0000_0077, '0);
        store(BASE + 12, 32'h0000_0078, '0);
        step(1'b1, 1'b1, BASE, 32'h1234_5678, '0);
        check("rst_valid", 32'(PORT_VALID), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);
        check("rst_p3_data", PORT_DATA[127:96], 32'h0);
        idle('0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iobus_out_demux.md
Name: iobus_out_demux

Overview:
- Write-side counterpart of the datapath select muxes: steers one CPU store on the memory-mapped IO bus to one of NUM_PORTS registered output ports.
- Each port presents a valid/ready handshake to its peripheral (display, keypad LEDs, modem TX, etc.).
- Sits between the OTTER-style CPU IOBUS and the phone peripherals.
- Also provides a control/status word for overrun tracking.

Parameters:
- NUM_PORTS, 4, number of output ports (1..8).
- BASE_ADDR, 32'h1100_0000, byte address of port 0.
- Port i is at BASE_ADDR+4*i.
- The control/status word is at CTRL_ADDR = BASE_ADDR+4*NUM_PORTS.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- IOBUS_ADDR  input  32  CPU IO address.
- IOBUS_OUT  input  32  CPU store data.
- IOBUS_WR  input  1  store strobe; one cycle per store.
- PORT_DATA  output  32*NUM_PORTS  flattened port data registers; port i occupies bits [32*i+31:32*i].
- PORT_VALID  output  NUM_PORTS  per-port data-pending flag.
- PORT_READY  input  NUM_PORTS  per-port peripheral accept.
- OVERRUN  output  NUM_PORTS  sticky per-port overrun flags.
- ADDR_ERR  output  1  one-cycle pulse on a bad write inside the decode window.
- IOBUS_IN  output  32  status readback; active only with STATUS_READ_EN.

Behaviour:
- Reset: on a clock edge with RST=1, clear all state. PORT_DATA=0, PORT_VALID=0, OVERRUN=0, ADDR_ERR=0. RST dominates every simultaneous event. Pending data is discarded with no handshake completion.
- Decode window: [BASE_ADDR, CTRL_ADDR+3].
  - Port hit: IOBUS_WR=1, IOBUS_ADDR[1:0]=0, address = BASE_ADDR+4*i, i<NUM_PORTS.
  - Ctrl hit: IOBUS_WR=1, aligned, address = CTRL_ADDR.
  - Error: IOBUS_WR=1 with an address inside the window but misaligned. On the next edge ADDR_ERR=1 for exactly one cycle. No state changes.
  - Writes outside the window are silently ignored (the block shares the bus).
- Per-port FSM, two states:
  - IDLE (PORT_VALID=0):
    - Port hit: load PORT_DATA[i] <= IOBUS_OUT, go to PENDING. Latency: data and valid visible 1 cycle after the store.
  - PENDING (PORT_VALID=1):
    - PORT_READY[i]=1, no hit: transfer complete, go to IDLE. PORT_DATA holds its last value.
    - PORT_READY[i]=1 and a hit in the same cycle: old word is accepted, new word loads, stay PENDING. No overrun.
    - PORT_READY[i]=0 and a hit: new word overwrites the old, stay PENDING, set OVERRUN[i]=1.
    - Neither: hold.
- PORT_READY while IDLE is ignored.
- PORT_DATA changes only on a port hit or reset. It is stable while PENDING until accept.
- Control word write:
  - IOBUS_OUT[NUM_PORTS-1:0] is a write-1-to-clear mask for OVERRUN.
  - If a clear and a new overrun on the same port coincide, set wins (OVERRUN stays 1).
  - IOBUS_OUT[31] = 1 flushes: all PORT_VALID cleared next edge. PORT_DATA is unchanged and OVERRUN is unaffected unless also masked.
- Only one store per cycle, so at most one port changes by CPU action per cycle. Handshakes on all ports proceed independently and in parallel.
- Total RTL: decoder, NUM_PORTS FSMs and registers, control logic, optional read mux.

Optional Feature:
- Macro: IOBUS_OUT_DEMUX_STATUS_READ_EN.
- When defined, IOBUS_IN is combinational, same cycle, from IOBUS_ADDR:
  - IOBUS_ADDR = CTRL_ADDR: {8'b0, OVERRUN zero-extended to 8, 8'b0, PORT_VALID zero-extended to 8}, i.e. PORT_VALID in bits[7:0] and OVERRUN in bits[23:16].
  - IOBUS_ADDR = port i address: PORT_DATA[i].
  - Otherwise: 0.
- When not defined: IOBUS_IN is tied to 32'h0. No read mux logic is synthesised.

Test Plan:
- Reset, then idle 5 cycles: PORT_VALID=0, OVERRUN=0, PORT_DATA all 0, ADDR_ERR never 1.
- Store 32'hDEAD_BEEF to BASE_ADDR+8, READY[2]=0: next cycle PORT_DATA[2]=DEAD_BEEF, VALID[2]=1. Hold READY low 3 cycles, then assert for 1 cycle: VALID[2]=0 the following cycle, data unchanged.
- Port 1 PENDING, READY[1]=0, store 32'h1234 to port 1: PORT_DATA[1]=1234, VALID[1]=1, OVERRUN[1]=1. Repeat with READY[1]=1 in the store cycle: OVERRUN stays 0 from a cleared start.
- Write 32'h0000_0002 to CTRL_ADDR: OVERRUN[1] clears. Write 32'h8000_0000 with ports 0 and 3 pending: both VALID drop next cycle.
- Store to BASE_ADDR+6: ADDR_ERR pulses 1 cycle, no port changes. Store to BASE_ADDR-4: nothing.
- With STATUS_READ_EN, VALID=4'b0101, OVERRUN=4'b0010, IOBUS_ADDR=CTRL_ADDR: IOBUS_IN=32'h0002_0005. Assert RST mid-PENDING: all flags 0 next edge.
